// File: rtl/vaccine_slots_ctrl.sv
`timescale 1ns/1ps
// Falling vaccine slots: a per-frame walker moves/retires slots, a periodic spawner
// fills the lowest free slot, and every slot reports whether the current pixel hits its box.

module vaccine_slot #(
  parameter int OBJ_W      = 32,
  parameter int OBJ_H      = 32,
  parameter int SCREEN_H   = 480,
  parameter int FALL_SPEED = 2
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     i_move,
  input  logic                     i_hit,
  input  logic                     i_spawn,
  input  logic [10:0]              i_spawnX,
  input  logic [10:0]              i_pixelX,
  input  logic [10:0]              i_pixelY,
  output logic                     o_active,
  output logic                     o_inBox,
  output logic [$clog2(OBJ_W)-1:0] o_offX,
  output logic [$clog2(OBJ_H)-1:0] o_offY
);
  localparam int XW = $clog2(OBJ_W);
  localparam int YW = $clog2(OBJ_H);

  logic        r_active;
  logic [10:0] r_x, r_y;
  logic [11:0] w_px, w_py, w_x, w_y, w_yNext;

  assign w_px    = {1'b0, i_pixelX};
  assign w_py    = {1'b0, i_pixelY};
  assign w_x     = {1'b0, r_x};
  assign w_y     = {1'b0, r_y};
  assign w_yNext = w_y + 12'(FALL_SPEED);

  // A hit always wins: it clears the slot even if a move or spawn targets it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (i_hit) begin
      r_active <= 1'b0;
    end else if (i_spawn) begin
      r_active <= 1'b1;
      r_x      <= i_spawnX;
      r_y      <= '0;
    end else if (i_move && r_active) begin
      if (w_yNext >= 12'(SCREEN_H)) r_active <= 1'b0;
      else                          r_y      <= w_yNext[10:0];
    end
  end

  assign o_active = r_active;
  assign o_inBox  = r_active &&
                    (w_px >= w_x) && (w_px < w_x + 12'(OBJ_W)) &&
                    (w_py >= w_y) && (w_py < w_y + 12'(OBJ_H));
  assign o_offX   = XW'(i_pixelX - r_x);
  assign o_offY   = YW'(i_pixelY - r_y);
endmodule

module vaccine_slots_ctrl #(
  parameter int          NUM_SLOTS    = 10,
  parameter int          OBJ_W        = 32,
  parameter int          OBJ_H        = 32,
  parameter int          SCREEN_H     = 480,
  parameter int          FALL_SPEED   = 2,
  parameter int          SPAWN_PERIOD = 64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     enable,
  input  logic [10:0]              pixelX,
  input  logic [10:0]              pixelY,
  input  logic                     hitValid,
  input  logic [3:0]               hitSlot,
  output logic [NUM_SLOTS-1:0]     vaccineRectDR,
  output logic [$clog2(OBJ_W)-1:0] offsetX,
  output logic [$clog2(OBJ_H)-1:0] offsetY,
  output logic [NUM_SLOTS-1:0]     activeMask,
  output logic                     busy
);
  localparam int XW  = $clog2(OBJ_W);
  localparam int YW  = $clog2(OBJ_H);
  localparam int IW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int FCW = $clog2(SPAWN_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SPAWN} state_t;

  state_t                         r_state;
  logic [IW-1:0]                  r_idx;
  logic [FCW-1:0]                 r_frameCnt;
  logic [15:0]                    r_lfsr;
  logic                           r_busy;

  logic [NUM_SLOTS-1:0]           w_active, w_inBox, w_move, w_hit, w_free, w_spawnVec;
  logic [NUM_SLOTS-1:0][XW-1:0]   w_offX;
  logic [NUM_SLOTS-1:0][YW-1:0]   w_offY;
  logic [XW-1:0]                  w_selX;
  logic [YW-1:0]                  w_selY;
  logic                           w_spawnDue, w_lfsrFb;
  logic [10:0]                    w_spawnX;

  assign w_lfsrFb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_spawnX   = {2'b00, r_lfsr[8:0]} + 11'd32;
  assign w_spawnDue = (r_state == S_SPAWN) && (r_frameCnt == FCW'(SPAWN_PERIOD-1));
  // Lowest free slot as a one-hot, taken from the pre-hit active bits.
  assign w_free     = ~w_active;
  assign w_spawnVec = w_spawnDue ? (w_free & (~w_free + NUM_SLOTS'(1))) : '0;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign w_move[g] = (r_state == S_MOVE) && (r_idx == IW'(g));
    assign w_hit[g]  = hitValid && (hitSlot == 4'(g));

    vaccine_slot #(
      .OBJ_W      (OBJ_W),
      .OBJ_H      (OBJ_H),
      .SCREEN_H   (SCREEN_H),
      .FALL_SPEED (FALL_SPEED)
    ) u_slot (
      .clk      (clk),
      .resetN   (resetN),
      .i_move   (w_move[g]),
      .i_hit    (w_hit[g]),
      .i_spawn  (w_spawnVec[g]),
      .i_spawnX (w_spawnX),
      .i_pixelX (pixelX),
      .i_pixelY (pixelY),
      .o_active (w_active[g]),
      .o_inBox  (w_inBox[g]),
      .o_offX   (w_offX[g]),
      .o_offY   (w_offY[g])
    );
  end

  // Descending scan so the lowest-index hitting slot supplies the offsets.
  always_comb begin
    w_selX = '0;
    w_selY = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (w_inBox[i]) begin
        w_selX = w_offX[i];
        w_selY = w_offY[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {w_lfsrFb, r_lfsr[15:1]};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_frameCnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (startOfFrame && enable) begin
            r_state <= S_MOVE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_MOVE: begin
          if (r_idx == IW'(NUM_SLOTS-1)) r_state <= S_SPAWN;
          else                           r_idx   <= r_idx + IW'(1);
        end
        S_SPAWN: begin
          r_frameCnt <= (r_frameCnt == FCW'(SPAWN_PERIOD-1)) ? '0 : r_frameCnt + FCW'(1);
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vaccineRectDR <= '0;
      offsetX       <= '0;
      offsetY       <= '0;
    end else begin
      vaccineRectDR <= w_inBox;
      offsetX       <= w_selX;
      offsetY       <= w_selY;
    end
  end

  assign activeMask = w_active;
  assign busy       = r_busy;
endmodule

// File: tb/tb_vaccine_slots_ctrl.sv
`timescale 1ns/1ps
// Bench for vaccine_slots_ctrl: two instances (default period, and period 2 to reach a full
// slot table) compared against a frame-level reference model of the slot rules.
module tb_vaccine_slots_ctrl;
  localparam int NS = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 resetN, startOfFrame, enable, hitValid;
  logic [10:0]          pixelX, pixelY;
  logic [3:0]           hitSlot;
  logic [1:0][NS-1:0]   dr, am;
  logic [1:0][4:0]      ox, oy;
  logic [1:0]           busy;

  vaccine_slots_ctrl u_dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .pixelX(pixelX), .pixelY(pixelY), .hitValid(hitValid), .hitSlot(hitSlot),
    .vaccineRectDR(dr[0]), .offsetX(ox[0]), .offsetY(oy[0]),
    .activeMask(am[0]), .busy(busy[0]));

  vaccine_slots_ctrl #(.SPAWN_PERIOD(2)) u_dut1 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .pixelX(pixelX), .pixelY(pixelY), .hitValid(hitValid), .hitSlot(hitSlot),
    .vaccineRectDR(dr[1]), .offsetX(ox[1]), .offsetY(oy[1]),
    .activeMask(am[1]), .busy(busy[1]));

  // Reference model: slot table per instance, updated once per completed frame.
  bit          m_act [2][NS];
  int          m_x   [2][NS];
  int          m_y   [2][NS];
  int          m_fc  [2];
  logic [15:0] m_lfsr;

  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk or negedge resetN)
    if (!resetN) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

  function automatic int period(input int k);
    return (k == 0) ? 64 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NS-1:0] m_mask(input int k);
    logic [NS-1:0] m;
    m = '0;
    for (int i = 0; i < NS; i++) m[i] = m_act[k][i];
    return m;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_fc[k] = 0;
      for (int i = 0; i < NS; i++) begin
        m_act[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0;
      end
    end
  endtask

  // One frame: fall/retire every active slot, apply a hit seen during the walk, then spawn.
  task automatic m_frame(input bit hit, input int hs, input logic [15:0] lv);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NS; i++)
        if (m_act[k][i]) begin
          if (m_y[k][i] + 2 >= 480) m_act[k][i] = 0;
          else                      m_y[k][i] += 2;
        end
      if (hit && hs < NS) m_act[k][hs] = 0;
      if (m_fc[k] == period(k) - 1) begin
        m_fc[k] = 0;
        for (int i = 0; i < NS; i++)
          if (!m_act[k][i]) begin
            m_act[k][i] = 1; m_x[k][i] = int'(lv[8:0]) + 32; m_y[k][i] = 0;
            break;
          end
      end else begin
        m_fc[k]++;
      end
    end
  endtask

  task automatic probe(input int px, input int py);
    logic [NS-1:0] edr;
    int eox, eoy;
    bit found;
    @(negedge clk);
    pixelX = 11'(px); pixelY = 11'(py);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      edr = '0; eox = 0; eoy = 0; found = 0;
      for (int i = 0; i < NS; i++)
        if (m_act[k][i] && px >= m_x[k][i] && px < m_x[k][i] + 32 &&
            py >= m_y[k][i] && py < m_y[k][i] + 32) begin
          edr[i] = 1'b1;
          if (!found) begin found = 1; eox = px - m_x[k][i]; eoy = py - m_y[k][i]; end
        end
      check($sformatf("rectDR%0d(%0d,%0d)", k, px, py), dr[k], edr);
      check($sformatf("offX%0d(%0d,%0d)", k, px, py), ox[k], eox);
      check($sformatf("offY%0d(%0d,%0d)", k, px, py), oy[k], eoy);
    end
  endtask

  task automatic check_state();
    int q[$];
    int k, s;
    for (int j = 0; j < 2; j++) check($sformatf("activeMask%0d", j), am[j], m_mask(j));
    probe($urandom_range(0, 600), $urandom_range(0, 511));
    k = $urandom_range(0, 1);
    for (int i = 0; i < NS; i++) if (m_act[k][i]) q.push_back(i);
    if (q.size() > 0) begin
      s = q[$urandom_range(0, q.size() - 1)];
      probe(m_x[k][s] + $urandom_range(0, 32), m_y[k][s] + $urandom_range(0, 32));
    end
  endtask

  task automatic do_hit(input int s);
    @(negedge clk); hitValid = 1'b1; hitSlot = 4'(s);
    @(negedge clk); hitValid = 1'b0;
    for (int k = 0; k < 2; k++) if (s < NS) m_act[k][s] = 0;
  endtask

  task automatic run_frame(input bit en, input bit mid_hit, input int hs, input int hcyc,
                           input bit drop_en);
    logic [15:0] lv;
    lv = '0;
    @(negedge clk); startOfFrame = 1'b1; enable = en;
    @(negedge clk); startOfFrame = 1'b0;
    if (!en) begin
      check("busy_disabled0", busy[0], 0);
      check("busy_disabled1", busy[1], 0);
    end else begin
      for (int c = 1; c <= 11; c++) begin
        check($sformatf("busy_walk%0d", c), busy, 2'b11);
        if (mid_hit && c == hcyc) begin hitValid = 1'b1; hitSlot = 4'(hs); end
        else hitValid = 1'b0;
        if (drop_en && c == 2) enable = 1'b0;
        if (c == 11) lv = m_lfsr;
        @(negedge clk);
      end
      check("busy_done", busy, 2'b00);
      enable = 1'b1;
      m_frame(mid_hit, hs, lv);
    end
  endtask

  initial begin
    bit en, mh, de;
    int hs, hc;
    resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; hitValid = 1'b0;
    hitSlot = '0; pixelX = '0; pixelY = '0;
    m_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_dr%0d", k), dr[k], 0);
      check($sformatf("rst_mask%0d", k), am[k], 0);
      check($sformatf("rst_offs%0d", k), {ox[k], oy[k]}, 0);
      check($sformatf("rst_busy%0d", k), busy[k], 0);
    end
    @(negedge clk); resetN = 1'b1;

    // Directed run: first spawn at frame 64, full table on the fast instance,
    // a hit inside the walk, and slot 0 of instance 0 falling to retirement.
    for (int f = 1; f <= 330; f++) begin
      run_frame(1'b1, f == 100, 5, 6, 1'b0);
      if (f == 30) begin do_hit(3); do_hit(12); end
      if (f == 63)  check("no_spawn_63", am[0], 0);
      if (f == 64)  check("spawn_64", am[0], 1);
      if (f == 30)  check("full_after_hit3", am[1], 10'h3F7);
      if (f == 32)  check("refill_slot3", am[1], 10'h3FF);
      if (f == 114) begin
        probe(m_x[0][0] + 5, 105);
        probe(m_x[0][0] + 32, 105);
      end
      if (f == 303) check("alive_y478", am[0][0], 1);
      if (f == 304) check("retired", am[0][0], 0);
      check_state();
    end

    // Randomized run: enable gaps, mid-walk enable drop, hits during and between walks.
    for (int f = 0; f < 300; f++) begin
      en = ($urandom_range(0, 7) != 0);
      mh = ($urandom_range(0, 3) == 0);
      hs = $urandom_range(0, 15);
      hc = $urandom_range(1, 10);
      de = ($urandom_range(0, 7) == 0);
      run_frame(en, mh, hs, hc, de);
      if ($urandom_range(0, 3) == 0) do_hit($urandom_range(0, 15));
      check_state();
    end

    // Reset in the middle of a walk.
    @(negedge clk); startOfFrame = 1'b1; enable = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", busy, 2'b11);
    resetN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_dr%0d", k), dr[k], 0);
      check($sformatf("midrst_mask%0d", k), am[k], 0);
      check($sformatf("midrst_offs%0d", k), {ox[k], oy[k]}, 0);
      check($sformatf("midrst_busy%0d", k), busy[k], 0);
    end
    @(negedge clk); resetN = 1'b1;
    m_reset();
    check_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
